// File: rtl/conv_frame_engine_if.sv
// Control and memory-port bundle between the 3x3 frame engine and its ROM/RAM neighbours.
// master is the engine side; slave is the memory/controller side.
interface conv_frame_engine_if #(
   parameter int ADDR_W = 18,
   parameter int PIX_W  = 8
);
   logic              start;
   logic              mode;
   logic              busy;
   logic              finish;
   logic [ADDR_W-1:0] src_addr;
   logic              src_re;
   logic [PIX_W-1:0]  src_data;
   logic [ADDR_W-1:0] dst_addr;
   logic [PIX_W-1:0]  dst_data;
   logic              dst_we;

   modport master (
      input  start, mode, src_data,
      output busy, finish, src_addr, src_re, dst_addr, dst_data, dst_we
   );

   modport slave (
      output start, mode, src_data,
      input  busy, finish, src_addr, src_re, dst_addr, dst_data, dst_we
   );
endinterface

// File: rtl/conv_frame_engine.sv
// Self-sequencing 3x3 convolution / copy engine: streams a raster frame through two line
// buffers into a 3x3 window, writes interior results, then fills the border.
module conv_frame_engine #(
   parameter int                   IMG_W      = 512,
   parameter int                   IMG_H      = 512,
   parameter int                   PIX_W      = 8,
   parameter int                   ADDR_W     = 18,
   parameter int                   COEF_W     = 8,
   parameter logic [9*COEF_W-1:0]  KERNEL     = 72'h01_02_01_02_04_02_01_02_01,
   parameter int                   SHIFT      = 4,
   parameter logic [PIX_W-1:0]     BORDER_VAL = '0
) (
   input logic              clk,
   input logic              rst_n,
   conv_frame_engine_if.master bus
);
   localparam int SUM_W = PIX_W + COEF_W + 4;
   localparam int CW    = $clog2(IMG_W);
   localparam int RW    = $clog2(IMG_H);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_W      = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);
   localparam logic [ADDR_W-1:0] BOT_ROW  = ADDR_W'((IMG_H - 1) * IMG_W);
   localparam logic [ADDR_W-1:0] B2       = ADDR_W'(2 * IMG_W);
   localparam logic [ADDR_W-1:0] B3       = ADDR_W'(2 * IMG_W + IMG_H - 2);
   localparam logic [ADDR_W-1:0] NB       = ADDR_W'(2 * IMG_W + 2 * IMG_H - 4);
   localparam logic signed [SUM_W-1:0] MAXV = SUM_W'((1 << PIX_W) - 1);

   typedef enum logic [2:0] {S_IDLE, S_STREAM, S_DRAIN, S_BORDER, S_DONE} state_t;
   state_t state_reg, state_next;

   logic              mode_reg;
   logic [ADDR_W-1:0] rd_addr_reg, bcnt_reg, baddr_d_reg, baddr;
   logic [CW-1:0]     col_reg, c1_reg;
   logic [RW-1:0]     row_reg;
   logic [1:0]        drain_reg;
   logic              v1_reg, wr1_reg, wr2_reg;
   logic [ADDR_W-1:0] a1_reg, a2_reg;
   logic [PIX_W-1:0]  lb0_q_reg, lb1_q_reg;
   logic [PIX_W-1:0]  win_reg [9];
   logic              pipe_we_reg;
   logic [ADDR_W-1:0] pipe_addr_reg;
   logic [PIX_W-1:0]  pipe_data_reg;
   logic [PIX_W-1:0]  lb0_mem [IMG_W];
   logic [PIX_W-1:0]  lb1_mem [IMG_W];
   logic signed [SUM_W-1:0] prod [9];
   logic signed [SUM_W-1:0] sum, shifted;
   logic [PIX_W-1:0]  result;
   logic              border_we;

   // Window slot gi pairs with kernel tap gi; k0 sits in the top bits of KERNEL.
   generate
      for (genvar gi = 0; gi < 9; gi++) begin : g_tap
         localparam logic [COEF_W-1:0] K = KERNEL[(8 - gi) * COEF_W +: COEF_W];
         assign prod[gi] = $signed({{(SUM_W - PIX_W){1'b0}}, win_reg[gi]})
                         * $signed({{(SUM_W - COEF_W){K[COEF_W-1]}}, K});
      end
   endgenerate

   always_comb begin
      sum = '0;
      for (int i = 0; i < 9; i++) sum = sum + prod[i];
      shifted = sum >>> SHIFT;
      if (mode_reg)                result = win_reg[4];
      else if (shifted[SUM_W-1])   result = '0;
      else if (shifted > MAXV)     result = '1;
      else                         result = shifted[PIX_W-1:0];
   end

   // Border walk: top row, bottom row, left column, right column (corners only in the rows).
   always_comb begin
      baddr = '0;
      if (bcnt_reg < A_W)      baddr = bcnt_reg;
      else if (bcnt_reg < B2)  baddr = bcnt_reg - A_W + BOT_ROW;
      else if (bcnt_reg < B3)  baddr = (bcnt_reg - B2 + ONE) * A_W;
      else                     baddr = (bcnt_reg - B3 + ONE) * A_W + A_W - ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next   = state_reg;
      bus.busy     = 1'b0;
      bus.finish   = 1'b0;
      bus.src_re   = 1'b0;
      bus.src_addr = '0;
      border_we    = 1'b0;
      case (state_reg)
         S_IDLE:   if (bus.start) state_next = S_STREAM;
         S_STREAM: begin
            bus.busy     = 1'b1;
            bus.src_re   = 1'b1;
            bus.src_addr = rd_addr_reg;
            if (rd_addr_reg == LAST_PIX) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            bus.busy = 1'b1;
            if (drain_reg == 2'd2) state_next = S_BORDER;
         end
         S_BORDER: begin
            bus.busy = 1'b1;
            if (mode_reg) begin
               // Copy re-reads each border pixel; the write trails its read by one cycle.
               bus.src_re   = (bcnt_reg != NB);
               bus.src_addr = (bcnt_reg != NB) ? baddr : '0;
               border_we    = (bcnt_reg != '0);
               if (bcnt_reg == NB) state_next = S_DONE;
            end else begin
               border_we = 1'b1;
               if (bcnt_reg == NB - ONE) state_next = S_DONE;
            end
         end
         S_DONE: begin
            bus.finish = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      bus.dst_we   = pipe_we_reg | border_we;
      bus.dst_addr = border_we ? (mode_reg ? baddr_d_reg : baddr) : pipe_addr_reg;
      bus.dst_data = border_we ? (mode_reg ? bus.src_data : BORDER_VAL) : pipe_data_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_reg    <= 1'b0;
         rd_addr_reg <= '0;
         col_reg     <= '0;
         row_reg     <= '0;
         drain_reg   <= '0;
         bcnt_reg    <= '0;
         baddr_d_reg <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               rd_addr_reg <= '0;
               col_reg     <= '0;
               row_reg     <= '0;
               drain_reg   <= '0;
               bcnt_reg    <= '0;
               if (bus.start) mode_reg <= bus.mode;
            end
            S_STREAM: begin
               rd_addr_reg <= rd_addr_reg + ONE;
               if (col_reg == CW'(IMG_W - 1)) begin
                  col_reg <= '0;
                  row_reg <= row_reg + 1'b1;
               end else begin
                  col_reg <= col_reg + 1'b1;
               end
            end
            S_DRAIN:  drain_reg <= drain_reg + 2'd1;
            S_BORDER: begin
               bcnt_reg    <= bcnt_reg + ONE;
               baddr_d_reg <= baddr;
            end
            default: ;
         endcase
      end
   end

   // Three-stage interior pipeline: read issued, window shifted, result registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_reg        <= 1'b0;
         wr1_reg       <= 1'b0;
         a1_reg        <= '0;
         c1_reg        <= '0;
         wr2_reg       <= 1'b0;
         a2_reg        <= '0;
         pipe_we_reg   <= 1'b0;
         pipe_addr_reg <= '0;
         pipe_data_reg <= '0;
         for (int i = 0; i < 9; i++) win_reg[i] <= '0;
      end else begin
         v1_reg  <= (state_reg == S_STREAM);
         wr1_reg <= (state_reg == S_STREAM) && (row_reg >= RW'(2)) && (col_reg >= CW'(2));
         a1_reg  <= rd_addr_reg;
         c1_reg  <= col_reg;
         wr2_reg <= v1_reg && wr1_reg;
         a2_reg  <= a1_reg;
         if (v1_reg) begin
            for (int r = 0; r < 3; r++) begin
               win_reg[r*3]     <= win_reg[r*3 + 1];
               win_reg[r*3 + 1] <= win_reg[r*3 + 2];
            end
            win_reg[2] <= lb1_q_reg;
            win_reg[5] <= lb0_q_reg;
            win_reg[8] <= bus.src_data;
         end
         pipe_we_reg   <= wr2_reg;
         pipe_addr_reg <= wr2_reg ? (a2_reg - A_W - ONE) : '0;
         pipe_data_reg <= wr2_reg ? result : '0;
      end
   end

   // Line buffers: read column for the pixel being fetched, write the previous pixel's column.
   always_ff @(posedge clk) begin
      if (v1_reg) begin
         lb0_mem[c1_reg] <= bus.src_data;
         lb1_mem[c1_reg] <= lb0_q_reg;
      end
      lb0_q_reg <= lb0_mem[col_reg];
      lb1_q_reg <= lb1_mem[col_reg];
   end
endmodule

// File: tb/tb_conv_frame_engine.sv
// Scoreboarded bench for conv_frame_engine: three kernel configurations on 8x8 frames,
// expected writes come from a direct arithmetic model of the 3x3 filter and border walk.
module tb_conv_frame_engine;
   localparam int W = 8, H = 8, AW = 6, PW = 8, N = W * H;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_frame_engine_if #(.ADDR_W(AW), .PIX_W(PW)) b0 ();
   conv_frame_engine_if #(.ADDR_W(AW), .PIX_W(PW)) b1 ();
   conv_frame_engine_if #(.ADDR_W(AW), .PIX_W(PW)) b2 ();

   conv_frame_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .COEF_W(8),
      .KERNEL(72'h01_02_01_02_04_02_01_02_01), .SHIFT(4), .BORDER_VAL(8'd0))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   conv_frame_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .COEF_W(8),
      .KERNEL(72'h01_01_01_01_01_01_01_01_01), .SHIFT(0), .BORDER_VAL(8'd0))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   conv_frame_engine #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW), .COEF_W(8),
      .KERNEL(72'hFF_FF_FF_FF_FF_FF_FF_FF_FF), .SHIFT(0), .BORDER_VAL(8'd0))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   logic [7:0] img [N];

   // Synchronous source ROMs: data one cycle after the read enable.
   always @(posedge clk) begin
      if (b0.src_re) b0.src_data <= img[b0.src_addr];
      if (b1.src_re) b1.src_data <= img[b1.src_addr];
      if (b2.src_re) b2.src_data <= img[b2.src_addr];
   end

   int sel = 0;
   logic m_we, m_finish, m_busy, m_re, other_we;
   logic [AW-1:0] m_addr, m_src_addr;
   logic [PW-1:0] m_data;
   always_comb begin
      m_we = 1'b0; m_finish = 1'b0; m_busy = 1'b0; m_re = 1'b0;
      m_addr = '0; m_src_addr = '0; m_data = '0; other_we = 1'b0;
      case (sel)
         0: begin
            m_we = b0.dst_we; m_finish = b0.finish; m_busy = b0.busy; m_re = b0.src_re;
            m_addr = b0.dst_addr; m_src_addr = b0.src_addr; m_data = b0.dst_data;
            other_we = b1.dst_we | b2.dst_we;
         end
         1: begin
            m_we = b1.dst_we; m_finish = b1.finish; m_busy = b1.busy; m_re = b1.src_re;
            m_addr = b1.dst_addr; m_src_addr = b1.src_addr; m_data = b1.dst_data;
            other_we = b0.dst_we | b2.dst_we;
         end
         default: begin
            m_we = b2.dst_we; m_finish = b2.finish; m_busy = b2.busy; m_re = b2.src_re;
            m_addr = b2.dst_addr; m_src_addr = b2.src_addr; m_data = b2.dst_data;
            other_we = b0.dst_we | b1.dst_we;
         end
      endcase
   end

   int total = 0;
   int bad = 0;
   int fin_cnt = 0;
   bit [13:0] exp_q [$];
   int kern [3][9];
   int shft [3];

   task automatic check(input string name, input int got, input int expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", name, got, expv);
      end
   endtask

   // Monitor: every destination write pops the next expected (addr,data) pair.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_we) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write addr=%0d data=%0d expected=none", m_addr, m_data);
            end else begin
               bit [13:0] e;
               e = exp_q.pop_front();
               if ({m_addr, m_data} !== e) begin
                  bad++;
                  $display("FAIL dst_write got addr=%0d data=%0d expected addr=%0d data=%0d",
                           m_addr, m_data, e[13:8], e[7:0]);
               end
            end
         end
         if (other_we) begin
            total++;
            bad++;
            $display("FAIL idle_engine_write got=1 expected=0");
         end
         if (m_finish) fin_cnt++;
      end
   end

   function automatic int px(input int r, input int c);
      return int'(img[r * W + c]);
   endfunction

   task automatic build_expected(input int d, input bit m);
      int s, a;
      for (int r = 1; r < H - 1; r++)
         for (int c = 1; c < W - 1; c++) begin
            if (m) s = px(r, c);
            else begin
               s = 0;
               for (int dr = -1; dr <= 1; dr++)
                  for (int dc = -1; dc <= 1; dc++)
                     s += kern[d][(dr + 1) * 3 + dc + 1] * px(r + dr, c + dc);
               s = s >>> shft[d];
               if (s < 0) s = 0;
               if (s > 255) s = 255;
            end
            exp_q.push_back({6'(r * W + c), 8'(s)});
         end
      for (int i = 0; i < 2 * W + 2 * (H - 2); i++) begin
         if (i < W)                a = i;
         else if (i < 2 * W)       a = (H - 1) * W + (i - W);
         else if (i < 2 * W + H - 2) a = (i - 2 * W + 1) * W;
         else                      a = (i - (2 * W + H - 2) + 1) * W + W - 1;
         exp_q.push_back({6'(a), m ? img[a] : 8'd0});
      end
   endtask

   task automatic drive_start(input int d, input logic s, input logic m);
      case (d)
         0: begin b0.start = s; b0.mode = m; end
         1: begin b1.start = s; b1.mode = m; end
         default: begin b2.start = s; b2.mode = m; end
      endcase
   endtask

   // One frame: start, optional stray starts while busy (and one on the finish cycle).
   task automatic run_frame(input int d, input bit m, input bit extra, input int exp_delta);
      int first, fcyc;
      sel = d;
      exp_q.delete();
      build_expected(d, m);
      fin_cnt = 0;
      @(negedge clk); drive_start(d, 1'b1, m);
      @(negedge clk); drive_start(d, 1'b0, 1'b0);
      first = -1; fcyc = -1;
      for (int k = 0; k < 400 && fcyc < 0; k++) begin
         if (k > 0) @(negedge clk);
         if (m_re && first < 0) begin
            first = k;
            check("busy_at_first_read", int'(m_busy), 1);
            check("first_src_addr", int'(m_src_addr), 0);
         end
         if (m_finish) begin
            fcyc = k;
            check("busy_at_finish", int'(m_busy), 0);
         end
         drive_start(d, extra && first >= 0 &&
                     (k - first == 10 || k - first == 65 || k - first == 80 || fcyc >= 0),
                     1'($urandom_range(0, 1)));
      end
      if (fcyc < 0) check("finish_timeout", 0, 1);
      else check("finish_latency", fcyc - first, exp_delta);
      @(negedge clk); drive_start(d, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("finish_pulses", fin_cnt, 1);
      check("writes_left", exp_q.size(), 0);
      check("no_restart_busy", int'(m_busy), 0);
      check("no_restart_re", int'(m_re), 0);
      $display("frame engine=%0d mode=%0d extra_starts=%0d latency=%0d total=%0d bad=%0d",
               d, m, extra, fcyc - first, total, bad);
   endtask

   task automatic fill_random();
      for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < N; i++) img[i] = 8'(v);
   endtask

   initial begin
      kern[0] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
      kern[1] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
      kern[2] = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
      shft = '{4, 0, 0};
      drive_start(0, 1'b0, 1'b0);
      drive_start(1, 1'b0, 1'b0);
      drive_start(2, 1'b0, 1'b0);
      fill_const(0);
      repeat (3) @(negedge clk);
      check("reset_busy", int'(b0.busy | b1.busy | b2.busy), 0);
      check("reset_we", int'(b0.dst_we | b1.dst_we | b2.dst_we), 0);
      check("reset_re", int'(b0.src_re | b1.src_re | b2.src_re), 0);
      check("reset_finish", int'(b0.finish | b1.finish | b2.finish), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      fill_const(16);          run_frame(0, 1'b0, 1'b0, 95);
      fill_const(0); img[3 * W + 3] = 8'd255;
                               run_frame(0, 1'b0, 1'b0, 95);
      fill_random();           run_frame(0, 1'b0, 1'b0, 95);
      for (int i = 0; i < N; i++) img[i] = 8'(i);
                               run_frame(0, 1'b1, 1'b0, 96);
      fill_random();           run_frame(0, 1'b1, 1'b0, 96);
      fill_const(255);         run_frame(1, 1'b0, 1'b0, 95);
                               run_frame(2, 1'b0, 1'b0, 95);
      fill_random();           run_frame(1, 1'b0, 1'b0, 95);
      fill_random();           run_frame(2, 1'b1, 1'b0, 96);

      // Reset 20 cycles into the stream: outputs drop at once, no finish follows.
      fill_random();
      sel = 0;
      fin_cnt = 0;
      @(negedge clk); drive_start(0, 1'b1, 1'b0);
      @(negedge clk); drive_start(0, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      check("pre_reset_busy", int'(b0.busy), 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_busy", int'(b0.busy), 0);
      check("async_reset_re", int'(b0.src_re), 0);
      check("async_reset_src_addr", int'(b0.src_addr), 0);
      check("async_reset_we", int'(b0.dst_we), 0);
      check("async_reset_dst_addr", int'(b0.dst_addr), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("reset_no_finish", int'(b0.finish), 0);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_reset_finish_pulses", fin_cnt, 0);
      check("post_reset_idle", int'(b0.busy), 0);
      fill_random();           run_frame(0, 1'b0, 1'b0, 95);

      fill_random();           run_frame(0, 1'b0, 1'b1, 95);
      fill_random();           run_frame(0, 1'b1, 1'b1, 96);
      fill_random();           run_frame(1, 1'b0, 1'b1, 95);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
